// File: rtl/ball_collision_engine.sv
// ball_collision_engine: per-step brick probing, wall/platform/brick bounce resolution and brick health write-back.
module ball_collision_engine #(
  parameter int COORD_W  = 10,
  parameter int HEALTH_W = 2,
  parameter int BRICK_W  = 20,
  parameter int BRICK_H  = 10,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int PLAT_Y   = 110,
  parameter int PLAT_W   = 20
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                step,
  input  logic [COORD_W-1:0]  ball_x,
  input  logic [COORD_W-1:0]  ball_y,
  input  logic [COORD_W-1:0]  size,
  input  logic [COORD_W-1:0]  platx,
  output logic                rd_req,
  output logic [COORD_W-1:0]  rd_x,
  output logic [COORD_W-1:0]  rd_y,
  input  logic                rd_ack,
  input  logic [HEALTH_W-1:0] rd_health,
  output logic                wr_en,
  output logic [COORD_W-1:0]  wr_x,
  output logic [COORD_W-1:0]  wr_y,
  output logic [HEALTH_W-1:0] wr_health,
  output logic                x_dir,
  output logic                y_dir,
  output logic                busy,
  output logic                done,
  output logic                ball_lost
);
  localparam int W = COORD_W + 1;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] BW = W'(BRICK_W);
  localparam logic [W-1:0] BH = W'(BRICK_H);
  localparam logic [W-1:0] SW = W'(SCREEN_W);
  localparam logic [W-1:0] SH = W'(SCREEN_H);
  localparam logic [W-1:0] PY = W'(PLAT_Y);
  localparam logic [W-1:0] PW = W'(PLAT_W);
  // Probe states are encoded 0..3 so the state doubles as the probe index.
  typedef enum logic [3:0] {
    PY1 = 4'd0, PY2 = 4'd1, PX1 = 4'd2, PX2 = 4'd3,
    RESOLVE = 4'd4, WR1 = 4'd5, WR2 = 4'd6, DONE = 4'd7, IDLE = 4'd8
  } state_t;
  state_t state, state_n;
  logic [3:0][HEALTH_W-1:0] h;
  logic [3:0][W-1:0] ax, ay;
  logic [3:0] need, hit, pend;
  logic [W-1:0] x, y, sz, px, xs, ys, x2, y2, ex, ey;
  logic [1:0] pi, wi;
  logic dx, dy, lost, probing, plat, dup2, dup3;
  function automatic logic same(input logic [W-1:0] ax1, ay1, ax2, ay2);
    return ax1 / BW == ax2 / BW && ay1 / BH == ay2 / BH;
  endfunction
  assign x  = {1'b0, ball_x};
  assign y  = {1'b0, ball_y};
  assign sz = {1'b0, size};
  assign px = {1'b0, platx};
  assign xs = x + sz;
  assign ys = y + sz;
  assign x2 = xs - ONE;
  assign y2 = ys - ONE;
  // Leading edges use the directions captured at step accept, since RESOLVE updates x_dir/y_dir before write-back.
  assign ey = dy ? ys : y - ONE;
  assign ex = dx ? xs : x - ONE;
  assign ax = {ex, ex, x2, x};
  assign ay = {y2, y, ey, ey};
  assign plat = ys == PY && xs > px && x < px + PW;
  assign need[0] = (dy ? ys : y) % BH == '0 && (dy ? !(ys >= SH || plat) : y != '0);
  assign need[1] = need[0] && x2 / BW != x / BW;
  assign need[2] = (dx ? xs : x) % BW == '0 && (dx ? xs < SW : x != '0);
  assign need[3] = need[2] && y2 / BH != y / BH;
  assign hit = {|h[3], |h[2], |h[1], |h[0]};
  assign dup2 = (hit[0] && same(ax[2], ay[2], ax[0], ay[0])) || (hit[1] && same(ax[2], ay[2], ax[1], ay[1]));
  assign dup3 = (hit[0] && same(ax[3], ay[3], ax[0], ay[0])) || (hit[1] && same(ax[3], ay[3], ax[1], ay[1]));
  assign probing = state < RESOLVE;
  assign pi = state[1:0];
  assign wi = state == WR2 ? (pend[2] ? 2'd2 : 2'd3) : (pend[0] ? 2'd0 : 2'd1);
  assign rd_req = probing && need[pi];
  assign rd_x = rd_req ? ax[pi][COORD_W-1:0] : '0;
  assign rd_y = rd_req ? ay[pi][COORD_W-1:0] : '0;
  assign wr_en = (state == WR1 && |pend[1:0]) || (state == WR2 && |pend[3:2]);
  assign wr_x = wr_en ? ax[wi][COORD_W-1:0] : '0;
  assign wr_y = wr_en ? ay[wi][COORD_W-1:0] : '0;
  assign wr_health = wr_en ? h[wi] - HEALTH_W'(1) : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign ball_lost = done && lost;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (step ? PY1 : IDLE)
            : probing ? ((!need[pi] || rd_ack) ? state_t'(state + 4'd1) : state)
            : state == WR1 ? (&pend[1:0] ? WR1 : WR2)
            : state == WR2 ? (&pend[3:2] ? WR2 : DONE)
            : state == DONE ? IDLE : WR1;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      h     <= '0;
      pend  <= '0;
      dx    <= 1'b0;
      dy    <= 1'b0;
      x_dir <= 1'b0;
      y_dir <= 1'b0;
      lost  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && step) begin
        h  <= '0;
        dx <= x_dir;
        dy <= y_dir;
      end
      if (rd_req && rd_ack) h[pi] <= rd_health;
      if (state == RESOLVE) begin
        pend  <= {hit[3] && !dup3, hit[2] && !dup2, hit[1:0]};
        y_dir <= y == '0 ? 1'b1 : (ys >= SH || plat) ? 1'b0 : |hit[1:0] ? !dy : dy;
        x_dir <= x == '0 ? 1'b1 : xs >= SW ? 1'b0 : |hit[3:2] ? !dx : dx;
        lost  <= y != '0 && ys >= SH;
      end
      if (wr_en) pend[wi] <= 1'b0;
    end
  end
endmodule
